// File: rtl/fault_filter_latch.sv
// Window-comparator fault filter: debounces each flag over FILTER_LEN samples, latches trips,
// records the first tripped index and releases only on an accepted clear handshake.
module fault_filter_latch #(
    parameter int CHANNELS   = 4,
    parameter int FILTER_LEN = 8,
    localparam int NF = 2 * CHANNELS,
    localparam int CW = $clog2(FILTER_LEN + 1),
    localparam int IW = (NF > 1) ? $clog2(NF) : 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          enable_i,
    input  logic [NF-1:0] compare_i,
    input  logic [NF-1:0] mask_i,
    input  logic          clear_i,
    output logic          clear_ack_o,
    output logic          clear_nack_o,
    output logic          fault_o,
    output logic [NF-1:0] fault_flags_o,
    output logic [IW-1:0] first_idx_o,
    output logic [NF-1:0] active_o,
    output logic [7:0]    trip_cnt_o
);

    typedef enum logic {
        ARMED   = 1'b0,
        TRIPPED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q [NF];
    logic [CW-1:0]   cnt_d [NF];
    logic [NF-1:0]   flags_q, flags_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      trip_cnt_q, trip_cnt_d;
    logic [NF-1:0]   active_q, active_d;
    logic            ack_q, ack_d;
    logic            nack_q, nack_d;

    logic [NF-1:0]   live;
    logic [NF-1:0]   trip;
    logic            any_trip;
    logic            all_cnt_zero;
    logic [IW-1:0]   first_trip;
    logic            clear_ok;

    assign live = compare_i & ~mask_i & {NF{enable_i}};

    // Per-flag debounce counters; trip fires only on the edge that completes the run.
    always_comb begin
        trip         = '0;
        all_cnt_zero = 1'b1;
        for (int n = 0; n < NF; n++) begin
            cnt_d[n] = '0;
            if (live[n]) begin
                cnt_d[n] = (cnt_q[n] == CW'(FILTER_LEN)) ? cnt_q[n] : cnt_q[n] + CW'(1);
            end
            trip[n] = live[n] && (cnt_q[n] == CW'(FILTER_LEN - 1));
            if (cnt_q[n] != '0) begin
                all_cnt_zero = 1'b0;
            end
        end
    end

    assign any_trip = |trip;

    // Scan downward so the lowest tripping index is the last one written.
    always_comb begin
        first_trip = '0;
        for (int n = NF - 1; n >= 0; n--) begin
            if (trip[n]) begin
                first_trip = IW'(n);
            end
        end
    end

    assign clear_ok = (state_q == TRIPPED) && all_cnt_zero && !any_trip;

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q | trip;
        idx_d      = idx_q;
        trip_cnt_d = trip_cnt_q;
        active_d   = live;
        ack_d      = 1'b0;
        nack_d     = 1'b0;

        if (state_q == ARMED && any_trip) begin
            state_d    = TRIPPED;
            idx_d      = first_trip;
            trip_cnt_d = (trip_cnt_q == 8'hFF) ? 8'hFF : trip_cnt_q + 8'd1;
        end

        // A clear that coincides with a trip or a still-counting input is refused.
        if (clear_i) begin
            if (clear_ok) begin
                state_d = ARMED;
                flags_d = '0;
                idx_d   = '0;
                ack_d   = 1'b1;
            end else begin
                nack_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ARMED;
            flags_q    <= '0;
            idx_q      <= '0;
            trip_cnt_q <= '0;
            active_q   <= '0;
            ack_q      <= 1'b0;
            nack_q     <= 1'b0;
            for (int n = 0; n < NF; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            idx_q      <= idx_d;
            trip_cnt_q <= trip_cnt_d;
            active_q   <= active_d;
            ack_q      <= ack_d;
            nack_q     <= nack_d;
            for (int n = 0; n < NF; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign fault_o       = (state_q == TRIPPED);
    assign fault_flags_o = flags_q;
    assign first_idx_o   = idx_q;
    assign trip_cnt_o    = trip_cnt_q;
    assign active_o      = active_q;
    assign clear_ack_o   = ack_q;
    assign clear_nack_o  = nack_q;

endmodule

// File: tb/tb_fault_filter_latch.sv
// Directed bench for fault_filter_latch (CHANNELS=4, FILTER_LEN=8).
module tb_fault_filter_latch;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       enable_i;
  logic [7:0] compare_i;
  logic [7:0] mask_i;
  logic       clear_i;
  logic       clear_ack_o;
  logic       clear_nack_o;
  logic       fault_o;
  logic [7:0] fault_flags_o;
  logic [2:0] first_idx_o;
  logic [7:0] active_o;
  logic [7:0] trip_cnt_o;

  int checks = 0;
  int errors = 0;

  fault_filter_latch #(.CHANNELS(4), .FILTER_LEN(8)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .enable_i      (enable_i),
    .compare_i     (compare_i),
    .mask_i        (mask_i),
    .clear_i       (clear_i),
    .clear_ack_o   (clear_ack_o),
    .clear_nack_o  (clear_nack_o),
    .fault_o       (fault_o),
    .fault_flags_o (fault_flags_o),
    .first_idx_o   (first_idx_o),
    .active_o      (active_o),
    .trip_cnt_o    (trip_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one active edge, then settle before sampling or driving.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_i   = 1'b1;
    enable_i  = 1'b0;
    compare_i = 8'h00;
    mask_i    = 8'h00;
    clear_i   = 1'b0;
    tick(2);
    reset_i = 1'b0;
    tick(1);

    chk("rst_fault", fault_o, 0);
    chk("rst_flags", fault_flags_o, 0);
    chk("rst_idx", first_idx_o, 0);
    chk("rst_tripcnt", trip_cnt_o, 0);
    chk("rst_active", active_o, 0);
    chk("rst_ack", clear_ack_o, 0);
    chk("rst_nack", clear_nack_o, 0);

    // 1: flag 0 high for exactly 8 samples
    enable_i  = 1'b1;
    compare_i = 8'h01;
    tick(7);
    chk("t1_no_fault_at7", fault_o, 0);
    chk("t1_active", active_o, 8'h01);
    tick(1);
    chk("t1_fault", fault_o, 1);
    chk("t1_flags", fault_flags_o, 8'h01);
    chk("t1_idx", first_idx_o, 0);
    chk("t1_tripcnt", trip_cnt_o, 1);
    compare_i = 8'h00;
    tick(1);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("t1_ack", clear_ack_o, 1);
    chk("t1_nack", clear_nack_o, 0);
    chk("t1_cleared_fault", fault_o, 0);
    chk("t1_cleared_flags", fault_flags_o, 0);
    tick(1);
    chk("t1_ack_pulse", clear_ack_o, 0);

    // 2: 7 high, 1 low, 7 high -> counter restarts, no trip
    compare_i = 8'h08;
    tick(7);
    compare_i = 8'h00;
    tick(1);
    compare_i = 8'h08;
    tick(7);
    chk("t2_no_fault", fault_o, 0);
    chk("t2_flags", fault_flags_o, 0);
    compare_i = 8'h00;
    tick(1);

    // 3: simultaneous trips on 5 and 2 -> lowest index wins
    compare_i = 8'h24;
    tick(8);
    chk("t3_fault", fault_o, 1);
    chk("t3_idx", first_idx_o, 2);
    chk("t3_flags", fault_flags_o, 8'h24);
    chk("t3_tripcnt", trip_cnt_o, 2);
    compare_i = 8'h00;
    tick(1);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("t3_ack", clear_ack_o, 1);

    // 4: clear refused while input still asserted, accepted once low
    compare_i = 8'h02;
    tick(8);
    chk("t4_fault", fault_o, 1);
    chk("t4_idx", first_idx_o, 1);
    chk("t4_tripcnt", trip_cnt_o, 3);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("t4_nack", clear_nack_o, 1);
    chk("t4_nack_no_ack", clear_ack_o, 0);
    chk("t4_still_fault", fault_o, 1);
    chk("t4_still_flags", fault_flags_o, 8'h02);
    compare_i = 8'h00;
    tick(1);
    chk("t4_nack_pulse", clear_nack_o, 0);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("t4_ack", clear_ack_o, 1);
    chk("t4_ack_no_nack", clear_nack_o, 0);
    chk("t4_cleared_fault", fault_o, 0);
    chk("t4_cleared_flags", fault_flags_o, 0);
    chk("t4_cleared_idx", first_idx_o, 0);

    // Clear while ARMED is refused, and a held clear answers every cycle
    clear_i = 1'b1;
    tick(1);
    chk("armed_nack1", clear_nack_o, 1);
    chk("armed_no_ack1", clear_ack_o, 0);
    tick(1);
    chk("armed_nack2", clear_nack_o, 1);
    clear_i = 1'b0;
    tick(1);
    chk("armed_nack_end", clear_nack_o, 0);

    // Later trips OR into flags while index and trip count stay frozen
    compare_i = 8'h01;
    tick(8);
    chk("or_tripcnt_a", trip_cnt_o, 4);
    compare_i = 8'h00;
    tick(1);
    compare_i = 8'h10;
    tick(7);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("or_flags", fault_flags_o, 8'h11);
    chk("or_idx", first_idx_o, 0);
    chk("or_tripcnt_b", trip_cnt_o, 4);
    chk("or_clear_nack", clear_nack_o, 1);
    compare_i = 8'h00;
    tick(1);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("or_ack", clear_ack_o, 1);
    chk("or_cleared", fault_flags_o, 0);

    // active_o reflects compare & ~mask & enable, one cycle later
    compare_i = 8'h0F;
    mask_i    = 8'h05;
    tick(1);
    chk("active_masked", active_o, 8'h0A);
    compare_i = 8'h00;
    mask_i    = 8'h00;
    tick(1);
    chk("active_low", active_o, 0);

    // 5: masked flag never trips; disabled filter never trips
    mask_i    = 8'h10;
    compare_i = 8'h10;
    tick(20);
    chk("t5_mask_fault", fault_o, 0);
    chk("t5_mask_active", active_o, 0);
    mask_i    = 8'h00;
    enable_i  = 1'b0;
    compare_i = 8'hFF;
    tick(10);
    chk("t5_dis_fault", fault_o, 0);
    chk("t5_dis_active", active_o, 0);
    chk("t5_dis_tripcnt", trip_cnt_o, 4);

    // Disable after a trip keeps the latch; clear then accepted
    enable_i  = 1'b1;
    compare_i = 8'h80;
    tick(8);
    chk("t5_trip7_idx", first_idx_o, 7);
    chk("t5_trip7_cnt", trip_cnt_o, 5);
    enable_i = 1'b0;
    tick(1);
    chk("t5_dis_keeps_fault", fault_o, 1);
    chk("t5_dis_keeps_flags", fault_flags_o, 8'h80);
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    chk("t5_dis_ack", clear_ack_o, 1);
    chk("t5_dis_cleared", fault_o, 0);
    compare_i = 8'h00;
    enable_i  = 1'b1;
    tick(1);

    // 6: reset mid-filter, then a full run after release
    compare_i = 8'h40;
    tick(5);
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    chk("t6_rst_fault", fault_o, 0);
    chk("t6_rst_flags", fault_flags_o, 0);
    chk("t6_rst_tripcnt", trip_cnt_o, 0);
    chk("t6_rst_active", active_o, 0);
    tick(7);
    chk("t6_no_fault_at7", fault_o, 0);
    tick(1);
    chk("t6_fault", fault_o, 1);
    chk("t6_idx", first_idx_o, 6);
    chk("t6_flags", fault_flags_o, 8'h40);
    chk("t6_tripcnt", trip_cnt_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
